// File: rtl/gate_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_test_sequencer
// Description : Stimulus/response checker for the two-input gate block.
//               Walks a/b through the four input vectors, waits SETTLE_CYCLES
//               after each one, compares the seven gate outputs with golden
//               values and reports per-vector failures, a saturating count of
//               mismatched output bits and an overall pass flag.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters  : SETTLE_CYCLES (>=1)  cycles from driving a vector to sampling y
//               ERR_W                width of err_count (saturates at 2^ERR_W-1)
// Ports       : clk        in   rising-edge clock
//               rst_n      in   synchronous reset, active low
//               start      in   begin a run (sampled only when idle)
//               busy       out  run in progress (settle/check phases)
//               done       out  one-cycle pulse at the end of a run
//               a, b       out  registered stimulus to the gate block
//               y[6:0]     in   gate outputs: and,or,not,nand,nor,xor,xnor
//               fail_vec   out  bit i set if vector i had any mismatch
//               err_count  out  total mismatched output bits (saturating)
//               pass       out  last completed run had zero mismatches
// Build macro : GATE_SEQ_STOP_ON_FAIL_EN - when defined, the first failing
//               vector ends the run immediately.
// ============================================================================
module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             a,
    output logic             b,
    input  logic [6:0]       y,
    output logic [3:0]       fail_vec,
    output logic [ERR_W-1:0] err_count,
    output logic             pass
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    // Sum is wide enough to hold the largest count plus a 7-bit popcount.
    localparam int SUM_W = ((ERR_W > 3) ? ERR_W : 3) + 1;
    localparam logic [SUM_W-1:0] ERR_MAX     = SUM_W'((1 << ERR_W) - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       fail_vec_q, fail_vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;

    logic [6:0]       w_golden;
    logic [6:0]       w_mismatch;
    logic [2:0]       w_mis_cnt;
    logic [SUM_W-1:0] w_err_sum;
    logic [ERR_W-1:0] w_err_sat;
    logic             w_last;

    // The vector index doubles as the stimulus register: a = idx[1], b = idx[0].
    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign fail_vec  = fail_vec_q;
    assign err_count = err_q;
    assign pass      = pass_q;

    assign w_golden = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    assign w_mismatch = y ^ w_golden;

    always_comb begin
        w_mis_cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            w_mis_cnt = w_mis_cnt + {2'b00, w_mismatch[i]};
        end
    end

    assign w_err_sum = SUM_W'(err_q) + SUM_W'(w_mis_cnt);
    assign w_err_sat = (w_err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : w_err_sum[ERR_W-1:0];

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    // Any mismatching bit terminates the run at this vector.
    assign w_last = (idx_q == 2'd3) || (w_mis_cnt != 3'd0);
`else
    assign w_last = (idx_q == 2'd3);
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        fail_vec_d = fail_vec_q;
        err_d      = err_q;
        pass_d     = pass_q;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d      = 2'd0;
                    fail_vec_d = 4'd0;
                    err_d      = '0;
                    pass_d     = 1'b0;
                    cnt_d      = SETTLE_LOAD;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy  = 1'b1;
                err_d = w_err_sat;
                if (w_mis_cnt != 3'd0) begin
                    fail_vec_d[idx_q] = 1'b1;
                end
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                pass_d  = (err_q == '0) && (fail_vec_q == 4'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            fail_vec_q <= 4'd0;
            err_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            fail_vec_q <= fail_vec_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
        end
    end

endmodule
`default_nettype wire
